// File: rtl/gf2m_283_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module   : gf2m_283_reduce_seq
// Brief    : Multi-cycle reducer of a 565-bit carry-less product modulo
//            f(x) = x^283 + x^12 + x^7 + x^5 + 1, CHUNK bits folded per cycle.
// Revision : 1.0
// ============================================================================
module gf2m_283_reduce_seq #(
  parameter int CHUNK = 47
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [564:0] in_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [282:0] out_r,
  output logic         busy
);

  localparam int M       = 283;
  localparam int W       = 2 * M - 1;
  localparam int NSTEP   = (M - 1) / CHUNK;
  localparam int SW      = $clog2(NSTEP + 1);
  localparam int LSB_TOP = W - CHUNK;

  generate
    if ((((M - 1) % CHUNK) != 0) || (CHUNK > 141)) begin : g_bad_chunk
      $error("gf2m_283_reduce_seq: CHUNK must divide 282 and be <= 141");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_step;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  w_mask;
  logic [W-1:0]  w_slice;
  logic [W-1:0]  w_fold;
  logic [9:0]    w_lsb;

  // Everything above the current slice is already zero, so masking from the
  // slice LSB upward isolates exactly the slice bits.
  assign w_lsb   = 10'(LSB_TOP) - 10'(int'(r_step) * CHUNK);
  assign w_mask  = {W{1'b1}} << w_lsb;
  assign w_slice = r_acc & w_mask;
  assign w_fold  = (r_acc ^ w_slice)
                 ^ (w_slice >> 283)
                 ^ (w_slice >> 278)
                 ^ (w_slice >> 276)
                 ^ (w_slice >> 271);

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    out_r       = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_FOLD;
        end
      end
      S_FOLD: begin
        busy = 1'b1;
        if (r_step == SW'(NSTEP - 1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_r     = r_acc[282:0];
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc  <= in_c;
            r_step <= '0;
          end
        end
        S_FOLD: begin
          r_acc  <= w_fold;
          r_step <= r_step + SW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf2m_283_reduce_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf2m_283_reduce_seq
// Brief    : Scoreboard bench for gf2m_283_reduce_seq at CHUNK = 47, 1, 6, 141.
// Revision : 1.0
// ============================================================================
module tb_gf2m_283_reduce_seq;

  localparam int NRAND = 40;
  localparam int NDUT  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;

  logic [282:0] ra [NRAND];
  logic [282:0] rb [NRAND];

  function automatic int chunk_of(input int g);
    case (g)
      0:       return 47;
      1:       return 1;
      2:       return 6;
      default: return 141;
    endcase
  endfunction

  function automatic logic [282:0] rand283();
    logic [287:0] v;
    for (int w = 0; w < 9; w++) v[w*32 +: 32] = $urandom;
    return v[282:0];
  endfunction

  function automatic logic [564:0] clmul(input logic [282:0] a, input logic [282:0] b);
    logic [564:0] p;
    p = '0;
    for (int i = 0; i < 283; i++) if (b[i]) p = p ^ (565'(a) << i);
    return p;
  endfunction

  // Bit-serial top-down reduction using x^283 = x^12 + x^7 + x^5 + 1.
  function automatic logic [282:0] reduce(input logic [564:0] c);
    logic [564:0] t;
    t = c;
    for (int i = 564; i >= 283; i--) begin
      if (t[i]) begin
        t[i]       = 1'b0;
        t[i - 283] = ~t[i - 283];
        t[i - 278] = ~t[i - 278];
        t[i - 276] = ~t[i - 276];
        t[i - 271] = ~t[i - 271];
      end
    end
    return t[282:0];
  endfunction

  task automatic chk(input string name, input logic [282:0] act, input logic [282:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NRAND; i++) begin
      ra[i] = rand283();
      rb[i] = rand283();
    end
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CH    = chunk_of(g);
    localparam int NSTEP = 282 / CH;
    localparam int RSTEP = (NSTEP > 3) ? 3 : NSTEP - 1;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [564:0] in_c;
    logic         out_valid;
    logic         out_ready;
    logic [282:0] out_r;
    logic         busy;
    logic [282:0] exp_q [$];
    logic [282:0] mon_e;

    gf2m_283_reduce_seq #(.CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_c      (in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .busy      (busy)
    );

    function automatic string nm(input string s);
      return $sformatf("c%0d %s", CH, s);
    endfunction

    // Issue one product from IDLE and return once out_valid is seen.
    task automatic send(input logic [564:0] c, input logic [282:0] e);
      int lat;
      @(posedge clk); #1;
      chk(nm("in_ready idle"), 283'(in_ready), 283'd1);
      in_valid = 1'b1;
      in_c     = c;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      in_valid = 1'b0;
      in_c     = ~c;
      lat      = 1;
      while (!out_valid && lat < NSTEP + 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk(nm("latency"), 283'(lat), 283'(NSTEP + 1));
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (out_valid && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk(nm("drained"), 283'(out_valid), 283'd0);
    endtask

    always @(negedge clk) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL c%0d spurious output: got %h, expected none", CH, out_r);
        end else begin
          mon_e = exp_q.pop_front();
          chk(nm("result"), out_r, mon_e);
        end
      end
    end

    initial begin
      logic [282:0] r;
      logic [564:0] p;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_c      = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk(nm("rst in_ready"),  283'(in_ready),  283'd1);
      chk(nm("rst out_valid"), 283'(out_valid), 283'd0);
      chk(nm("rst busy"),      283'(busy),      283'd0);
      chk(nm("rst out_r"),     out_r,           283'd0);
      rst = 1'b0;

      send('0, '0);                       drain();
      send(565'h1 << 283, 283'h10A1);     drain();
      send(565'h1 << 564, (283'h1 << 281) | 283'h401528); drain();
      r = rand283();
      send(565'(r), r);                   drain();

      // Backpressure: result must hold while extra requests are ignored.
      out_ready = 1'b0;
      r = rand283();
      p = clmul(r, ~r);
      send(p, reduce(p));
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        in_valid = i[0];
        in_c     = clmul(rand283(), rand283());
        chk(nm("bp out_r"),     out_r,            reduce(p));
        chk(nm("bp in_ready"),  283'(in_ready),   283'd0);
        chk(nm("bp out_valid"), 283'(out_valid),  283'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (3) @(posedge clk);
      #1;
      chk(nm("bp back idle"), 283'(in_ready), 283'd1);

      // Reset mid-fold discards the partial result.
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_c     = 565'h1 << 564;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (RSTEP) @(posedge clk);
      #1;
      chk(nm("fold busy"), 283'(busy), 283'd1);
      rst = 1'b1;
      #1;
      chk(nm("mid rst in_ready"),  283'(in_ready),  283'd1);
      chk(nm("mid rst out_valid"), 283'(out_valid), 283'd0);
      chk(nm("mid rst busy"),      283'(busy),      283'd0);
      chk(nm("mid rst out_r"),     out_r,           283'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      p = clmul(ra[0], rb[0]);
      send(p, reduce(p)); drain();

      for (int i = 0; i < NRAND; i++) begin
        p = clmul(ra[i], rb[i]);
        send(p, reduce(p));
        drain();
      end

      repeat (4) @(posedge clk);
      #1;
      chk(nm("queue empty"), 283'(exp_q.size()), 283'd0);
      n_done++;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (n_done < NDUT && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    if (n_done < NDUT) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got %0d finished drivers, expected %0d", n_done, NDUT);
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
